seven_seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-bus seven-segment display.

---
 rtl/seven_seg_pkg.sv | 29 ++
 rtl/seven_seg_decoder.sv | 33 +++
 rtl/seven_seg_scan_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
//   Shared definitions for the seven-segment scan controller:
//   - SEG_W        : width of the segment bus
//   - BLANK, ZERO..NINE : segment patterns in {a,b,c,d,e,f,g} order, active-high
//   - slot_state_t : per-slot phase (anti-ghost GAP, then SHOW)
// ---------------------------------------------------------------------------
package seven_seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] BLANK = 7'b000_0000;
    localparam logic [SEG_W-1:0] ZERO  = 7'b111_1110;
    localparam logic [SEG_W-1:0] ONE   = 7'b011_0000;
    localparam logic [SEG_W-1:0] TWO   = 7'b110_1101;
    localparam logic [SEG_W-1:0] THREE = 7'b111_1001;
    localparam logic [SEG_W-1:0] FOUR  = 7'b011_0011;
    localparam logic [SEG_W-1:0] FIVE  = 7'b101_1011;
    localparam logic [SEG_W-1:0] SIX   = 7'b001_1111;
    localparam logic [SEG_W-1:0] SEVEN = 7'b111_0000;
    localparam logic [SEG_W-1:0] EIGHT = 7'b111_1111;
    localparam logic [SEG_W-1:0] NINE  = 7'b111_1011;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } slot_state_t;

endpackage : seven_seg_pkg

// File: rtl/seven_seg_decoder.sv
// ---------------------------------------------------------------------------
// seven_seg_decoder
//   Combinational BCD to seven-segment decoder. Codes 10..15 are not valid
//   BCD and decode to BLANK.
// Ports:
//   bcd  in  4      BCD digit
//   seg  out SEG_W  segments {a,b,c,d,e,f,g}, active-high
// ---------------------------------------------------------------------------
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0]       bcd,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = BLANK;
        case (bcd)
            4'd0:    seg = ZERO;
            4'd1:    seg = ONE;
            4'd2:    seg = TWO;
            4'd3:    seg = THREE;
            4'd4:    seg = FOUR;
            4'd5:    seg = FIVE;
            4'd6:    seg = SIX;
            4'd7:    seg = SEVEN;
            4'd8:    seg = EIGHT;
            4'd9:    seg = NINE;
            default: seg = BLANK;
        endcase
    end

endmodule : seven_seg_decoder

// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
//   Time-multiplexed scan controller for an N-digit common-bus seven-segment
//   display. Each digit slot lasts REFRESH_DIV cycles and begins with
//   GHOST_CYCLES blank cycles so the previous digit's segments cannot ghost
//   onto the next digit. Values arrive through a Load/Ready handshake into a
//   one-deep pending buffer and are promoted to the displayed (active) value
//   only at frame boundaries, so a frame never mixes old and new digits.
//
// Ports:
//   clk      in   1             clock, rising edge
//   rst      in   1             asynchronous active-high reset
//   Load     in   1             capture request, accepted when Load && Ready
//   Value    in   4*NUM_DIGITS  packed BCD, digit k = Value[4k+3:4k]
//   LzbEn    in   1             leading-zero blanking enable (sampled every cycle)
//   Ready    out  1             pending buffer empty
//   Display  out  SEG_W         segment bus {a..g}, active-high, registered
//   DigitEn  out  NUM_DIGITS    one-hot digit enable, registered, 0 in gaps
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int GHOST_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Load,
    input  logic [4*NUM_DIGITS-1:0] Value,
    input  logic                    LzbEn,
    output logic                    Ready,
    output logic [SEG_W-1:0]        Display,
    output logic [NUM_DIGITS-1:0]   DigitEn
);

    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    // Last gap cycle; only meaningful when GHOST_CYCLES > 0.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GHOST_CYCLES > 0) ? GHOST_CYCLES - 1 : 0);
    // With no gap configured, every cycle of a slot is a SHOW cycle.
    localparam slot_state_t STATE_RST = (GHOST_CYCLES > 0) ? GAP : SHOW;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]      cnt_reg,           cnt_next;
    logic [IDX_W-1:0]      idx_reg,           idx_next;
    slot_state_t           state_reg,         state_next;
    logic [DATA_W-1:0]     active_reg,        active_next;
    logic [DATA_W-1:0]     pending_reg,       pending_next;
    logic                  pending_valid_reg, pending_valid_next;
    logic [SEG_W-1:0]      display_reg,       display_next;
    logic [NUM_DIGITS-1:0] digit_en_reg,      digit_en_next;

    logic slot_end;
    logic frame_end;
    logic accept;

    assign Ready   = ~pending_valid_reg;
    assign Display = display_reg;
    assign DigitEn = digit_en_reg;

    assign accept    = Load && Ready;
    assign slot_end  = (cnt_reg == CNT_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);

    // -----------------------------------------------------------------------
    // Slot / digit counters
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (slot_end) begin
            cnt_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // GAP/SHOW phase FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = SHOW;
                end
            end
            SHOW: begin
                if (slot_end) begin
                    state_next = STATE_RST;
                end
            end
            default: state_next = STATE_RST;
        endcase
    end

    // -----------------------------------------------------------------------
    // Pending / active value handling
    //   A value loaded exactly on the frame-boundary edge with an empty
    //   pending buffer skips the buffer and is shown from the new frame.
    // -----------------------------------------------------------------------
    always_comb begin
        active_next        = active_reg;
        pending_next       = pending_reg;
        pending_valid_next = pending_valid_reg;
        if (frame_end) begin
            if (pending_valid_reg) begin
                active_next        = pending_reg;
                pending_valid_next = 1'b0;
            end else if (accept) begin
                active_next = Value;
            end
        end else if (accept) begin
            pending_next       = Value;
            pending_valid_next = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Digit extraction, leading-zero mask and one-hot select, all evaluated
    // on the next-cycle value so the output registers line up with cnt/idx.
    // -----------------------------------------------------------------------
    logic [3:0]            digit_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] digit_zero;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [NUM_DIGITS-1:0] onehot_next;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_val[gi]   = active_next[4*gi +: 4];
        // Codes 10..15 are non-zero, so they stop leading-zero blanking.
        assign digit_zero[gi]  = (digit_val[gi] == 4'h0);
        assign onehot_next[gi] = (idx_next == IDX_W'(gi));
        if (gi == 0) begin : g_lsd
            // The least significant digit always shows, even for a zero value.
            assign blank_mask[gi] = 1'b0;
        end else begin : g_upper
            assign blank_mask[gi] = LzbEn && (&digit_zero[NUM_DIGITS-1:gi]);
        end
    end

    logic [3:0]       sel_digit;
    logic             sel_blank;
    logic [SEG_W-1:0] dec_seg;

    always_comb begin
        sel_digit = 4'h0;
        sel_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (onehot_next[k]) begin
                sel_digit = digit_val[k];
                sel_blank = blank_mask[k];
            end
        end
    end

    seven_seg_decoder u_decoder (
        .bcd (sel_digit),
        .seg (dec_seg)
    );

    always_comb begin
        display_next  = BLANK;
        digit_en_next = '0;
        if (state_next == SHOW) begin
            // Blanked digits keep their enable so scan timing stays uniform.
            digit_en_next = onehot_next;
            display_next  = sel_blank ? BLANK : dec_seg;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg           <= '0;
            idx_reg           <= '0;
            state_reg         <= STATE_RST;
            active_reg        <= '0;
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
            display_reg       <= BLANK;
            digit_en_reg      <= '0;
        end else begin
            cnt_reg           <= cnt_next;
            idx_reg           <= idx_next;
            state_reg         <= state_next;
            active_reg        <= active_next;
            pending_reg       <= pending_next;
            pending_valid_reg <= pending_valid_next;
            display_reg       <= display_next;
            digit_en_reg      <= digit_en_next;
        end
    end

endmodule : seven_seg_scan_ctrl

// File: tb/tb_seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
//   Scoreboard bench: the driver applies stimulus on falling edges, advances
//   a cycle-count based reference model and queues the expected outputs for
//   the following rising edge; an independent monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int RD    = 8;
    localparam int GH    = 2;
    localparam int FRAME = N * RD;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        Load  = 1'b0;
    logic        LzbEn = 1'b0;
    logic [15:0] Value = 16'h0;
    logic        Ready;
    logic [6:0]  Display;
    logic [3:0]  DigitEn;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (RD),
        .GHOST_CYCLES (GH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .Load    (Load),
        .Value   (Value),
        .LzbEn   (LzbEn),
        .Ready   (Ready),
        .Display (Display),
        .DigitEn (DigitEn)
    );

    always #5 clk = ~clk;

    // {Display, DigitEn, Ready}
    typedef logic [11:0] obs_t;

    obs_t exp_q[$];
    bit   mon_en = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    // Reference model: time since reset plus the displayed/pending values.
    int unsigned m_t;
    logic [15:0] m_active;
    logic [15:0] m_pend;
    bit          m_pv;

    logic [6:0] seg_tab [0:15];
    initial seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                        7'b0110011, 7'b1011011, 7'b0011111, 7'b1110000,
                        7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
                        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

    // Expected outputs for the cycle numbered m_t.
    function automatic obs_t model_out(input logic lz);
        int          phase;
        int          slot;
        logic [15:0] upper;
        logic [6:0]  disp;
        logic [3:0]  en;
        phase = int'(m_t % RD);
        slot  = int'((m_t / RD) % N);
        disp  = 7'b0;
        en    = 4'b0;
        if (phase >= GH) begin
            en    = 4'(1 << slot);
            upper = m_active >> (4 * slot);
            if (lz && slot != 0 && upper == 16'h0) disp = 7'b0;
            else                                   disp = seg_tab[upper[3:0]];
        end
        return {disp, en, ~m_pv};
    endfunction

    // Effect of one clock edge leaving cycle m_t.
    function automatic void model_edge(input logic ld, input logic [15:0] v);
        bit boundary;
        bit acc;
        boundary = ((m_t % FRAME) == FRAME - 1);
        acc      = ld && !m_pv;
        if (boundary) begin
            if (m_pv) begin
                m_active = m_pend;
                m_pv     = 1'b0;
            end else if (acc) begin
                m_active = v;
            end
        end else if (acc) begin
            m_pend = v;
            m_pv   = 1'b1;
        end
        m_t++;
    endfunction

    task automatic drive(input logic ld, input logic [15:0] v, input logic lz);
        Load  = ld;
        Value = v;
        LzbEn = lz;
        model_edge(ld, v);
        exp_q.push_back(model_out(lz));
    endtask

    task automatic step(input logic ld, input logic [15:0] v, input logic lz);
        @(negedge clk);
        drive(ld, v, lz);
    endtask

    task automatic chk(input string name, input obs_t act, input obs_t req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got disp=%b en=%b rdy=%b, want disp=%b en=%b rdy=%b",
                     name, act[11:5], act[4:1], act[0], req[11:5], req[4:1], req[0]);
        end
    endtask

    // Monitor: one comparison per rising edge while the scoreboard is live.
    obs_t mon_e;
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty at t=%0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                if ({Display, DigitEn, Ready} !== mon_e) begin
                    n_bad++;
                    $display("FAIL scan t=%0t: got disp=%b en=%b rdy=%b, want disp=%b en=%b rdy=%b",
                             $time, Display, DigitEn, Ready, mon_e[11:5], mon_e[4:1], mon_e[0]);
                end
            end
        end
    end

    task automatic release_reset();
        @(negedge clk);
        rst      = 1'b0;
        m_t      = 0;
        m_active = 16'h0;
        m_pend   = 16'h0;
        m_pv     = 1'b0;
        exp_q.delete();
        chk("post_reset", {Display, DigitEn, Ready}, {7'b0, 4'b0, 1'b1});
        drive(1'b0, 16'h0, 1'b0);
        mon_en = 1'b1;
    endtask

    task automatic idle(input int cycles, input logic lz);
        for (int i = 0; i < cycles; i++) step(1'b0, 16'h0, lz);
    endtask

    // Wait for an empty pending buffer, then load away from the boundary.
    task automatic load_when_ready(input logic [15:0] v, input logic lz);
        while (m_pv || (m_t % FRAME) == FRAME - 1) step(1'b0, 16'h0, lz);
        step(1'b1, v, lz);
    endtask

    function automatic logic [15:0] rand_value();
        logic [15:0] v;
        int          r;
        v = 16'h0;
        for (int k = 0; k < 4; k++) begin
            r = $urandom_range(0, 7);
            if (r < 3)      v[4*k +: 4] = 4'h0;
            else if (r < 6) v[4*k +: 4] = 4'($urandom_range(1, 9));
            else            v[4*k +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    task automatic run_random(input int cycles);
        logic lz;
        logic ld;
        lz = LzbEn;
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 63) == 0) lz = ~lz;
            ld = ($urandom_range(0, 11) == 0);
            // Exercise the bypass path on boundary edges regularly.
            if ((m_t % FRAME) == FRAME - 1 && !m_pv && $urandom_range(0, 1) == 1) ld = 1'b1;
            step(ld, rand_value(), lz);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", {Display, DigitEn, Ready}, {7'b0, 4'b0, 1'b1});
        release_reset();

        // Idle frame of zeros, then a load issued during digit 1.
        idle(40, 1'b0);
        while (((m_t / RD) % N) != 1) step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'h1234, 1'b0);
        idle(70, 1'b0);

        // Leading-zero blanking cases, including invalid codes.
        load_when_ready(16'h0070, 1'b1);
        idle(70, 1'b1);
        load_when_ready(16'h0000, 1'b1);
        idle(70, 1'b1);
        load_when_ready(16'h00A5, 1'b1);
        idle(70, 1'b1);
        load_when_ready(16'hA000, 1'b1);
        idle(70, 1'b1);

        // Second load while busy is dropped.
        while (m_pv || (m_t % FRAME) != 3) step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'h1111, 1'b0);
        step(1'b1, 16'h2222, 1'b0);
        idle(70, 1'b0);

        // Load exactly on the frame-boundary edge with an empty buffer.
        while (m_pv || (m_t % FRAME) != FRAME - 1) step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'h3333, 1'b0);
        idle(40, 1'b0);

        run_random(2500);

        // Asynchronous reset in the middle of digit 2 (cnt = 5).
        load_when_ready(16'h8888, 1'b0);
        while (m_pv || (m_t % FRAME) != 2 * RD + 5) step(1'b0, 16'h0, 1'b0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        chk("pre_reset_en", {7'b0, DigitEn, 1'b1}, {7'b0, 4'b0100, 1'b1});
        rst = 1'b1;
        #1;
        chk("async_reset", {Display, DigitEn, Ready}, {7'b0, 4'b0, 1'b1});
        repeat (2) @(negedge clk);
        release_reset();
        idle(40, 1'b0);

        run_random(1500);

        @(posedge clk);
        #3;
        mon_en = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seven_seg_scan_ctrl
